// File: rtl/h264_stream_packer.sv
// h264_stream_packer
// Packs the encoder's 16-bit byte-pair stream into 64-bit words with byte
// enables, buffers them in a FIFO behind a registered ready/valid port and
// reports each frame's length in bytes once the input has gone quiet.
module h264_stream_packer #(
    parameter int G_FIFO_DEPTH = 512,
    parameter int G_IDLE_CYC   = 16,
    parameter int G_LEN_W      = 32
) (
    input  logic                          PIX_CLK,
    input  logic                          RESET,
    input  logic                          FRAME_END_I,
    input  logic                          DATA_VALID_I,
    input  logic [15:0]                   DATA_I,
    output logic [63:0]                   M_DATA_O,
    output logic [7:0]                    M_KEEP_O,
    output logic                          M_LAST_O,
    output logic                          M_VALID_O,
    input  logic                          M_READY_I,
    output logic [G_LEN_W-1:0]            FRAME_LEN_O,
    output logic                          FRAME_LEN_VALID_O,
    output logic [$clog2(G_FIFO_DEPTH):0] FIFO_LEVEL_O,
    output logic                          OVERFLOW_O
);

    // state   | meaning
    // IDLE    | no data yet in the frame
    // ACTIVE  | packing pairs, waiting for the frame-end edge
    // DRAIN   | packing continues, idle timer runs on quiet cycles
    // FLUSH_P | push the pending word if a partial word follows it
    // FLUSH_Q | push the frame's final word with LAST set
    // DONE    | report frame length, clear frame state
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ACTIVE  = 3'd1;
    localparam logic [2:0] S_DRAIN   = 3'd2;
    localparam logic [2:0] S_FLUSH_P = 3'd3;
    localparam logic [2:0] S_FLUSH_Q = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam int          AW        = $clog2(G_FIFO_DEPTH);
    localparam int          LW        = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(G_FIFO_DEPTH);
    localparam logic [7:0]  TMR_LOAD  = 8'(G_IDLE_CYC);

    logic [2:0]         state;
    logic               fe_d;
    logic [47:0]        acc;
    logic [1:0]         pair_cnt;
    logic [63:0]        pend;
    logic               pend_vld;
    logic [G_LEN_W-1:0] byte_cnt;
    logic [7:0]         idle_tmr;

    logic               fe_rise, in_pack, accept, word_done;
    logic               push, push_last;
    logic [63:0]        push_data;
    logic [7:0]         push_keep;

    logic [72:0]        mem [G_FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr, rd_nxt;
    logic               full, pop, wr_en;
    logic [LW-1:0]      lvl_after_pop;

    // Input acceptance and selection of the single FIFO write per cycle.
    always_comb begin
        fe_rise   = FRAME_END_I & ~fe_d;
        in_pack   = (state == S_IDLE) || (state == S_ACTIVE) || (state == S_DRAIN);
        accept    = in_pack & DATA_VALID_I;
        word_done = accept && (pair_cnt == 2'd3);
        push      = 1'b0;
        push_data = pend;
        push_keep = 8'hFF;
        push_last = 1'b0;
        if (word_done && pend_vld) begin
            push = 1'b1;
        end else if (state == S_FLUSH_P) begin
            push = pend_vld && (pair_cnt != 2'd0);
        end else if (state == S_FLUSH_Q) begin
            push_last = 1'b1;
            case (pair_cnt)
                2'd1: begin
                    push      = 1'b1;
                    push_data = {acc[15:0], 48'h0};
                    push_keep = 8'hC0;
                end
                2'd2: begin
                    push      = 1'b1;
                    push_data = {acc[31:0], 32'h0};
                    push_keep = 8'hF0;
                end
                2'd3: begin
                    push      = 1'b1;
                    push_data = {acc[47:0], 16'h0};
                    push_keep = 8'hFC;
                end
                default: push = pend_vld;
            endcase
        end
    end

    // Frame FSM, pair accumulator, pending word, byte count and drop flag.
    always_ff @(posedge PIX_CLK) begin
        if (RESET) begin
            state             <= S_IDLE;
            fe_d              <= 1'b0;
            acc               <= '0;
            pair_cnt          <= '0;
            pend              <= '0;
            pend_vld          <= 1'b0;
            byte_cnt          <= '0;
            idle_tmr          <= '0;
            FRAME_LEN_O       <= '0;
            FRAME_LEN_VALID_O <= 1'b0;
            OVERFLOW_O        <= 1'b0;
        end else begin
            fe_d              <= FRAME_END_I;
            FRAME_LEN_VALID_O <= 1'b0;
            if (accept) begin
                acc      <= {acc[31:0], DATA_I};
                pair_cnt <= pair_cnt + 2'd1;
                byte_cnt <= byte_cnt + G_LEN_W'(2);
            end
            if (word_done) begin
                pend     <= {acc, DATA_I};
                pend_vld <= 1'b1;
            end else if (push && (state == S_FLUSH_P)) begin
                pend_vld <= 1'b0;
            end
            if ((DATA_VALID_I && !in_pack) || (push && !wr_en)) begin
                OVERFLOW_O <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (fe_rise) begin
                        state    <= S_DRAIN;
                        idle_tmr <= TMR_LOAD;
                    end else if (DATA_VALID_I) begin
                        state <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (fe_rise) begin
                        state    <= S_DRAIN;
                        idle_tmr <= TMR_LOAD;
                    end
                end
                S_DRAIN: begin
                    if (DATA_VALID_I) begin
                        idle_tmr <= TMR_LOAD;
                    end else if (idle_tmr == 8'd1) begin
                        state <= S_FLUSH_P;
                    end else begin
                        idle_tmr <= idle_tmr - 8'd1;
                    end
                end
                S_FLUSH_P: state <= S_FLUSH_Q;
                S_FLUSH_Q: begin
                    FRAME_LEN_VALID_O <= 1'b1;
                    FRAME_LEN_O       <= byte_cnt;
                    state             <= S_DONE;
                end
                S_DONE: begin
                    acc      <= '0;
                    pair_cnt <= '0;
                    pend     <= '0;
                    pend_vld <= 1'b0;
                    byte_cnt <= '0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // FIFO handshake terms; the output register counts as an occupied entry.
    always_comb begin
        full          = (FIFO_LEVEL_O == FULL_LVL);
        pop           = M_VALID_O & M_READY_I;
        wr_en         = push & (~full | pop);
        rd_nxt        = rd_ptr + AW'(pop);
        lvl_after_pop = FIFO_LEVEL_O - LW'(pop);
    end

    // FIFO storage, written without reset since the pointers define validity.
    always_ff @(posedge PIX_CLK) begin
        if (wr_en && !RESET) begin
            mem[wr_ptr] <= {push_last, push_keep, push_data};
        end
    end

    // FIFO pointers, level and registered output stage (holds while stalled).
    always_ff @(posedge PIX_CLK) begin
        if (RESET) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            FIFO_LEVEL_O <= '0;
            M_VALID_O    <= 1'b0;
            M_DATA_O     <= '0;
            M_KEEP_O     <= '0;
            M_LAST_O     <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr       <= rd_nxt;
            FIFO_LEVEL_O <= lvl_after_pop + LW'(wr_en);
            M_VALID_O    <= (lvl_after_pop != '0);
            if (lvl_after_pop != '0) begin
                {M_LAST_O, M_KEEP_O, M_DATA_O} <= mem[rd_nxt];
            end
        end
    end

endmodule

// File: tb/tb_h264_stream_packer.sv
// Bench for h264_stream_packer: byte-stream reference model with a single
// compare process, plus directed frames with literal expectations.
`timescale 1ns/1ps
module tb_h264_stream_packer;
    localparam int D  = 512;
    localparam int G  = 16;
    localparam int LW = 32;

    logic        clk;
    logic        rst;
    logic        FRAME_END_I, DATA_VALID_I, M_READY_I;
    logic [15:0] DATA_I;
    logic [63:0] M_DATA_O;
    logic [7:0]  M_KEEP_O;
    logic        M_LAST_O, M_VALID_O, FRAME_LEN_VALID_O, OVERFLOW_O;
    logic [LW-1:0] FRAME_LEN_O;
    logic [$clog2(D):0] FIFO_LEVEL_O;

    h264_stream_packer #(.G_FIFO_DEPTH(D), .G_IDLE_CYC(G), .G_LEN_W(LW)) dut (
        .PIX_CLK(clk), .RESET(rst), .FRAME_END_I(FRAME_END_I),
        .DATA_VALID_I(DATA_VALID_I), .DATA_I(DATA_I),
        .M_DATA_O(M_DATA_O), .M_KEEP_O(M_KEEP_O), .M_LAST_O(M_LAST_O),
        .M_VALID_O(M_VALID_O), .M_READY_I(M_READY_I),
        .FRAME_LEN_O(FRAME_LEN_O), .FRAME_LEN_VALID_O(FRAME_LEN_VALID_O),
        .FIFO_LEVEL_O(FIFO_LEVEL_O), .OVERFLOW_O(OVERFLOW_O)
    );

    typedef struct { logic [63:0] d; logic [7:0] k; logic l; } word_t;
    typedef struct { int len; longint at; } frm_t;

    word_t       exp_words[$];
    word_t       got_log[$];
    frm_t        exp_frames[$];
    logic [7:0]  cur_bytes[$];
    int          cur_len;
    longint      fe_cyc, last_act, cyc;
    bit          chk_en;
    int          rdy_mode;
    int          n_chk, n_fail;
    int          last_len;
    longint      last_len_cyc;
    logic        pv, pr;
    logic [72:0] pword;
    word_t       cw, ce;
    frm_t        cf;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sink ready: held low, held high or randomly toggled.
    initial begin
        M_READY_I = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       M_READY_I = 1'b0;
                1:       M_READY_I = 1'b1;
                default: M_READY_I = ($urandom_range(0, 99) < 55);
            endcase
        end
    end

    // The single compare process: transfers, stall stability, frame reports.
    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("stall_valid_held", M_VALID_O, 1);
                chk("stall_word_held", {M_LAST_O, M_KEEP_O, M_DATA_O}, pword);
            end
            if (M_VALID_O && M_READY_I) begin
                cw.d = M_DATA_O; cw.k = M_KEEP_O; cw.l = M_LAST_O;
                got_log.push_back(cw);
                if (chk_en) begin
                    if (exp_words.size() == 0) begin
                        chk("unexpected_word", exp_words.size(), 1);
                    end else begin
                        ce = exp_words.pop_front();
                        chk("word_data", M_DATA_O, ce.d);
                        chk("word_keep", M_KEEP_O, ce.k);
                        chk("word_last", M_LAST_O, ce.l);
                    end
                end
            end
            if (FRAME_LEN_VALID_O) begin
                last_len     = int'(FRAME_LEN_O);
                last_len_cyc = cyc;
            end
            if (chk_en) begin
                if (exp_frames.size() > 0 && exp_frames[0].at <= cyc) begin
                    cf = exp_frames.pop_front();
                    chk("frame_len_valid", FRAME_LEN_VALID_O, 1);
                    chk("frame_len", FRAME_LEN_O, cf.len);
                end else if (FRAME_LEN_VALID_O) begin
                    chk("frame_len_valid_unexpected", FRAME_LEN_VALID_O, 0);
                end
            end
            pv    = M_VALID_O;
            pr    = M_READY_I;
            pword = {M_LAST_O, M_KEEP_O, M_DATA_O};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_model();
        exp_words.delete();
        exp_frames.delete();
        cur_bytes.delete();
        got_log.delete();
    endtask

    task automatic start_frame();
        cur_bytes.delete();
        cur_len  = 0;
        last_act = -1;
        fe_cyc   = -1;
    endtask

    // Reference model: the frame is a byte sequence; any 8 bytes followed by
    // more data form a full non-final word.
    task automatic model_add(input logic [15:0] d);
        word_t w;
        cur_bytes.push_back(d[15:8]);
        cur_bytes.push_back(d[7:0]);
        cur_len += 2;
        if (cur_bytes.size() > 8) begin
            w.d = '0;
            for (int i = 0; i < 8; i++) w.d[63-8*i -: 8] = cur_bytes.pop_front();
            w.k = 8'hFF;
            w.l = 1'b0;
            exp_words.push_back(w);
        end
    endtask

    task automatic send_pair(input logic [15:0] d);
        DATA_VALID_I = 1'b1;
        DATA_I       = d;
        model_add(d);
        last_act = cyc;
        tick();
        DATA_VALID_I = 1'b0;
        DATA_I       = 16'($urandom);
    endtask

    task automatic frame_end();
        FRAME_END_I = 1'b1;
        fe_cyc      = cyc;
        tick();
        FRAME_END_I = 1'b0;
    endtask

    // Remaining bytes become the LAST word; the frame closes G+3 cycles after
    // the later of the frame-end edge and the last pair.
    task automatic finish_frame();
        word_t  w;
        longint close;
        if (cur_bytes.size() > 0) begin
            w.d = '0;
            w.k = '0;
            for (int i = 0; i < cur_bytes.size(); i++) begin
                w.d[63-8*i -: 8] = cur_bytes[i];
                w.k[7-i]         = 1'b1;
            end
            w.l = 1'b1;
            exp_words.push_back(w);
        end
        close = ((last_act > fe_cyc) ? last_act : fe_cyc) + G + 3;
        exp_frames.push_back('{cur_len, close});
        while (cyc <= close) tick();
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while (exp_words.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        chk("drain_words_left", exp_words.size(), 0);
        idle(3);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_m_valid"}, M_VALID_O, 0);
        chk({tag, "_m_last"}, M_LAST_O, 0);
        chk({tag, "_m_data"}, M_DATA_O, 0);
        chk({tag, "_m_keep"}, M_KEEP_O, 0);
        chk({tag, "_frame_len"}, FRAME_LEN_O, 0);
        chk({tag, "_frame_len_valid"}, FRAME_LEN_VALID_O, 0);
        chk({tag, "_fifo_level"}, FIFO_LEVEL_O, 0);
        chk({tag, "_overflow"}, OVERFLOW_O, 0);
    endtask

    initial begin
        logic [63:0] ew;
        int np, post, n;

        n_chk = 0; n_fail = 0; chk_en = 1'b0; rdy_mode = 1;
        last_len = -1; last_len_cyc = 0;
        rst = 1'b1; FRAME_END_I = 1'b0; DATA_VALID_I = 1'b0; DATA_I = '0;
        clear_model();
        idle(2);
        check_reset_values("reset");
        rst = 1'b0;
        idle(2);
        chk_en = 1'b1;

        // Single full word
        got_log.delete();
        start_frame();
        send_pair(16'h0001); send_pair(16'h0203); send_pair(16'h0405); send_pair(16'h0607);
        idle(2);
        frame_end();
        finish_frame();
        wait_drain(100);
        chk("t1_word_count", got_log.size(), 1);
        chk("t1_data", got_log[0].d, 64'h0001020304050607);
        chk("t1_keep", got_log[0].k, 8'hFF);
        chk("t1_last", got_log[0].l, 1);
        chk("t1_len", last_len, 8);

        // Five pairs: full word then partial word
        got_log.delete();
        start_frame();
        for (int i = 0; i < 5; i++) send_pair({8'(2*i), 8'(2*i+1)});
        frame_end();
        finish_frame();
        wait_drain(100);
        chk("t2_word_count", got_log.size(), 2);
        chk("t2_data0", got_log[0].d, 64'h0001020304050607);
        chk("t2_keep0", got_log[0].k, 8'hFF);
        chk("t2_last0", got_log[0].l, 0);
        chk("t2_data1", got_log[1].d, 64'h0809000000000000);
        chk("t2_keep1", got_log[1].k, 8'hC0);
        chk("t2_last1", got_log[1].l, 1);
        chk("t2_len", last_len, 10);

        // Empty frame
        got_log.delete();
        start_frame();
        frame_end();
        finish_frame();
        idle(5);
        chk("t3_word_count", got_log.size(), 0);
        chk("t3_len", last_len, 0);
        chk("t3_close_latency", last_len_cyc - fe_cyc, G + 3);
        chk("t3_m_valid", M_VALID_O, 0);

        // Pair arriving 11 cycles after the frame-end edge restarts the idle count
        got_log.delete();
        start_frame();
        send_pair(16'h0001); send_pair(16'h0203);
        idle(3);
        frame_end();
        idle(10);
        send_pair(16'h0405);
        finish_frame();
        wait_drain(100);
        chk("t4_close_latency", last_len_cyc - fe_cyc, G + 3 + 11);
        chk("t4_len", last_len, 6);
        chk("t4_data", got_log[0].d, 64'h0001020304050000);
        chk("t4_keep", got_log[0].k, 8'hFC);

        // Random frames under random backpressure, the last one larger
        rdy_mode = 2;
        for (int f = 0; f < 5; f++) begin
            np   = (f == 4) ? 3136 : $urandom_range(1, 700);
            post = $urandom_range(0, 3);
            if (post > np) post = 0;
            start_frame();
            for (int i = 0; i < np - post; i++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
                send_pair(16'($urandom));
            end
            idle($urandom_range(0, 3));
            frame_end();
            for (int i = 0; i < post; i++) begin
                idle($urandom_range(0, 3));
                send_pair(16'($urandom));
            end
            finish_frame();
            idle($urandom_range(0, 5));
        end
        wait_drain(20000);
        chk("rand_overflow", OVERFLOW_O, 0);
        chk("rand_frames_left", exp_frames.size(), 0);

        // FIFO fill with sink stalled, then drain
        chk_en   = 1'b0;
        rdy_mode = 0;
        idle(2);
        clear_model();
        start_frame();
        for (int i = 0; i < 4 * (D + 2); i++) send_pair(16'(i));
        frame_end();
        finish_frame();
        idle(3);
        chk("ovf_level_full", FIFO_LEVEL_O, D);
        chk("ovf_flag_set", OVERFLOW_O, 1);
        chk("ovf_len", last_len, 8 * (D + 2));
        rdy_mode = 1;
        n = 0;
        while (got_log.size() < D && n < 4 * D) begin
            tick();
            n++;
        end
        idle(10);
        chk("ovf_drain_count", got_log.size(), D);
        for (int k = 0; k < got_log.size() && k < D; k++) begin
            ew = {16'(4*k), 16'(4*k+1), 16'(4*k+2), 16'(4*k+3)};
            chk("ovf_drain_data", got_log[k].d, ew);
            chk("ovf_drain_last", got_log[k].l, 0);
        end
        chk("ovf_flag_sticky", OVERFLOW_O, 1);
        chk("ovf_level_empty", FIFO_LEVEL_O, 0);
        chk("ovf_valid_low", M_VALID_O, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ovf_cleared_by_reset", OVERFLOW_O, 0);
        clear_model();
        idle(2);

        // Reset in the middle of a frame with words in flight
        rdy_mode = 2;
        start_frame();
        for (int i = 0; i < 40; i++) send_pair(16'($urandom));
        rst = 1'b1;
        tick();
        check_reset_values("midreset");
        rst = 1'b0;
        clear_model();
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
